replay_seq_ctrl: RTL and testbench

//  Sequencer for the DLL TLP replay buffer. Assigns 12-bit sequence numbers to outgoing TLPs.

---
 rtl/replay_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_replay_seq_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/replay_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : replay_seq_ctrl
//  Description : DLL replay-buffer sequencer. Assigns sequence numbers, handles
//                ACK/NAK DLLPs and the replay timer, and re-issues unacked TLPs.
//                Optional statistics counters are enabled by REPLAY_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module replay_seq_ctrl #(
   parameter int SEQ_W      = 12,
   parameter int DEPTH      = 16,
   parameter int TIMER_W    = 16,
   parameter int TIMEOUT    = 1000,
   parameter int MAX_REPLAY = 3,
   localparam int IDX_W     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tlp_valid,
   output logic             tlp_ready,
   output logic [SEQ_W-1:0] tlp_seq,
   input  logic             busy_n,
   output logic             buf_wr,
   output logic [IDX_W-1:0] buf_wr_idx,
   output logic             buf_rd,
   output logic [IDX_W-1:0] buf_rd_idx,
   output logic [SEQ_W-1:0] replay_seq,
   input  logic [1:0]       ack_nack,
   input  logic [SEQ_W-1:0] ack_seq,
   input  logic             retrain_done,
   output logic             replay_active,
   output logic             retrain_req,
   output logic             dllp_err
`ifdef REPLAY_STATS_EN
   ,
   output logic [15:0]      nak_cnt,
   output logic [15:0]      timeout_cnt,
   output logic [15:0]      replay_cnt
`endif
);

   localparam int RN_W = $clog2(MAX_REPLAY + 2);

   localparam logic [1:0] ST_NORMAL  = 2'd0;
   localparam logic [1:0] ST_REPLAY  = 2'd1;
   localparam logic [1:0] ST_RETRAIN = 2'd2;

   localparam logic [SEQ_W-1:0]   SEQ_ONE   = SEQ_W'(1);
   localparam logic [SEQ_W-1:0]   DEPTH_S   = SEQ_W'(DEPTH);
   localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT - 1);
   localparam logic [RN_W-1:0]    RN_ONE    = RN_W'(1);
   localparam logic [RN_W-1:0]    RN_MAX    = RN_W'(MAX_REPLAY);

   logic [SEQ_W-1:0]   nts_q, nts_d;
   logic [SEQ_W-1:0]   as_q, as_d;
   logic [SEQ_W-1:0]   rp_q, rp_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [RN_W-1:0]    replay_num_q, replay_num_d;
   logic [1:0]         state_q, state_d;
   logic               retrain_req_q, retrain_req_d;
   logic               dllp_err_q, dllp_err_d;

   logic [SEQ_W-1:0]   w_out;
   logic [SEQ_W-1:0]   w_out_new;
   logic [SEQ_W-1:0]   w_dist;
   logic [SEQ_W-1:0]   w_rp_adv;
   logic [RN_W-1:0]    w_rn_base;
   logic               w_accept;
   logic               w_is_ack;
   logic               w_is_nak;
   logic               w_is_dllp;
   logic               w_dup;
   logic               w_upd;
   logic               w_nak_seen;
   logic               w_timeout;
   logic               w_trigger;
   logic               w_rd_fire;
   logic               w_rd_last;

   // Outstanding count: AS is the last acked sequence, so the window is (AS, NTS).
   assign w_out      = nts_q - as_q - SEQ_ONE;

   assign tlp_ready  = (state_q == ST_NORMAL) & busy_n & (w_out < DEPTH_S);
   assign w_accept   = tlp_valid & tlp_ready;
   assign buf_wr     = w_accept;
   assign buf_wr_idx = nts_q[IDX_W-1:0];
   assign tlp_seq    = nts_q;

   assign w_is_ack   = (ack_nack == 2'b01);
   assign w_is_nak   = (ack_nack == 2'b10);
   assign w_is_dllp  = w_is_ack | w_is_nak;
   assign w_dist     = ack_seq - as_q;
   assign w_dup      = w_is_dllp & (w_dist == '0);
   assign w_upd      = w_is_dllp & (w_dist != '0) & (w_dist <= w_out);
   assign w_nak_seen = w_is_nak & (w_upd | w_dup);
   assign dllp_err_d = w_is_dllp & (w_dist != '0) & (w_dist > w_out);

   assign nts_d      = w_accept ? (nts_q + SEQ_ONE) : nts_q;
   assign as_d       = w_upd ? ack_seq : as_q;
   assign w_out_new  = nts_d - as_d - SEQ_ONE;

   assign w_rd_fire  = (state_q == ST_REPLAY) & busy_n;
   assign w_rd_last  = w_rd_fire & (rp_q == (nts_q - SEQ_ONE));
   assign buf_rd     = w_rd_fire;
   assign buf_rd_idx = rp_q[IDX_W-1:0];
   assign replay_seq = rp_q;

   assign w_timeout  = (state_q == ST_NORMAL) & (timer_q == TMO_LAST) & (w_out != '0);

   // A valid ACK in the timeout cycle suppresses the replay.
   assign w_trigger  = (state_q == ST_NORMAL) & (w_out_new != '0) &
                       (w_nak_seen | (w_timeout & ~(w_is_ack & w_upd)));

   assign w_rn_base  = w_upd ? '0 : replay_num_q;
   assign w_rp_adv   = w_rd_fire ? (rp_q + SEQ_ONE) : rp_q;

   always_comb begin
      state_d       = state_q;
      rp_d          = w_rp_adv;
      replay_num_d  = w_rn_base;
      retrain_req_d = 1'b0;
      timer_d       = '0;
      case (state_q)
         ST_NORMAL: begin
            if (w_trigger) begin
               if (w_rn_base == RN_MAX) begin
                  replay_num_d  = '0;
                  retrain_req_d = 1'b1;
                  state_d       = ST_RETRAIN;
               end else begin
                  replay_num_d  = w_rn_base + RN_ONE;
                  state_d       = ST_REPLAY;
                  rp_d          = as_d + SEQ_ONE;
               end
            end else if ((w_out_new != '0) && !w_upd) begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         ST_REPLAY: begin
            // An ACK that reaches the replay pointer skips the already-acked slots.
            if (w_upd && (w_dist >= (w_rp_adv - as_q))) begin
               rp_d = as_d + SEQ_ONE;
            end
            if ((w_out_new == '0) || w_rd_last) begin
               state_d = ST_NORMAL;
            end
         end
         ST_RETRAIN: begin
            if (retrain_done) begin
               if (w_out_new == '0) begin
                  state_d = ST_NORMAL;
               end else begin
                  state_d = ST_REPLAY;
                  rp_d    = as_d + SEQ_ONE;
               end
            end
         end
         default: begin
            state_d = ST_NORMAL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nts_q         <= '0;
         as_q          <= '1;
         rp_q          <= '0;
         timer_q       <= '0;
         replay_num_q  <= '0;
         state_q       <= ST_NORMAL;
         retrain_req_q <= 1'b0;
         dllp_err_q    <= 1'b0;
      end else begin
         nts_q         <= nts_d;
         as_q          <= as_d;
         rp_q          <= rp_d;
         timer_q       <= timer_d;
         replay_num_q  <= replay_num_d;
         state_q       <= state_d;
         retrain_req_q <= retrain_req_d;
         dllp_err_q    <= dllp_err_d;
      end
   end

   assign replay_active = (state_q != ST_NORMAL);
   assign retrain_req   = retrain_req_q;
   assign dllp_err      = dllp_err_q;

`ifdef REPLAY_STATS_EN
   logic [15:0] nak_cnt_q, nak_cnt_d;
   logic [15:0] timeout_cnt_q, timeout_cnt_d;
   logic [15:0] replay_cnt_q, replay_cnt_d;
   logic        w_enter_replay;

   assign w_enter_replay = (state_d == ST_REPLAY) & (state_q != ST_REPLAY);

   always_comb begin
      nak_cnt_d     = nak_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      replay_cnt_d  = replay_cnt_q;
      if (w_nak_seen && (nak_cnt_q != 16'hFFFF)) begin
         nak_cnt_d = nak_cnt_q + 16'd1;
      end
      if (w_timeout && (timeout_cnt_q != 16'hFFFF)) begin
         timeout_cnt_d = timeout_cnt_q + 16'd1;
      end
      if (w_enter_replay && (replay_cnt_q != 16'hFFFF)) begin
         replay_cnt_d = replay_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nak_cnt_q     <= '0;
         timeout_cnt_q <= '0;
         replay_cnt_q  <= '0;
      end else begin
         nak_cnt_q     <= nak_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         replay_cnt_q  <= replay_cnt_d;
      end
   end

   assign nak_cnt     = nak_cnt_q;
   assign timeout_cnt = timeout_cnt_q;
   assign replay_cnt  = replay_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_replay_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_replay_seq_ctrl
//  Description : Directed self-checking bench for replay_seq_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_replay_seq_ctrl;

   localparam int TIMEOUT = 1000;

   logic        clk;
   logic        rst;
   logic        tlp_valid;
   logic        tlp_ready;
   logic [11:0] tlp_seq;
   logic        busy_n;
   logic        buf_wr;
   logic [3:0]  buf_wr_idx;
   logic        buf_rd;
   logic [3:0]  buf_rd_idx;
   logic [11:0] replay_seq;
   logic [1:0]  ack_nack;
   logic [11:0] ack_seq;
   logic        retrain_done;
   logic        replay_active;
   logic        retrain_req;
   logic        dllp_err;
`ifdef REPLAY_STATS_EN
   logic [15:0] nak_cnt;
   logic [15:0] timeout_cnt;
   logic [15:0] replay_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   replay_seq_ctrl #(
      .SEQ_W      (12),
      .DEPTH      (16),
      .TIMER_W    (16),
      .TIMEOUT    (TIMEOUT),
      .MAX_REPLAY (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tlp_valid     (tlp_valid),
      .tlp_ready     (tlp_ready),
      .tlp_seq       (tlp_seq),
      .busy_n        (busy_n),
      .buf_wr        (buf_wr),
      .buf_wr_idx    (buf_wr_idx),
      .buf_rd        (buf_rd),
      .buf_rd_idx    (buf_rd_idx),
      .replay_seq    (replay_seq),
      .ack_nack      (ack_nack),
      .ack_seq       (ack_seq),
      .retrain_done  (retrain_done),
      .replay_active (replay_active),
      .retrain_req   (retrain_req),
      .dllp_err      (dllp_err)
`ifdef REPLAY_STATS_EN
      ,
      .nak_cnt       (nak_cnt),
      .timeout_cnt   (timeout_cnt),
      .replay_cnt    (replay_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got running exp finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst          = 1'b1;
      tlp_valid    = 1'b0;
      busy_n       = 1'b1;
      ack_nack     = 2'b00;
      ack_seq      = '0;
      retrain_done = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic send_tlps(input int n);
      tlp_valid = 1'b1;
      for (int i = 0; i < n; i++) tick;
      tlp_valid = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      #1;
      n_checks++;
      if ({tlp_ready, replay_active, buf_wr, buf_rd, retrain_req, dllp_err} !== 6'b100000) begin
         n_errors++;
         $display("FAIL reset_flags: got %b exp 100000",
                  {tlp_ready, replay_active, buf_wr, buf_rd, retrain_req, dllp_err});
      end
      n_checks++;
      if (tlp_seq !== 12'd0) begin
         n_errors++;
         $display("FAIL reset_nts: got %0d exp 0", tlp_seq);
      end
   endtask

   task automatic test_accept;
      do_reset;
      tlp_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if ({buf_wr, tlp_seq, buf_wr_idx} !== {1'b1, 12'(i), 4'(i)}) begin
            n_errors++;
            $display("FAIL accept_%0d: got wr=%b seq=%0d idx=%0d exp wr=1 seq=%0d idx=%0d",
                     i, buf_wr, tlp_seq, buf_wr_idx, i, i);
         end
         tick;
      end
      tlp_valid = 1'b0;
      #1;
      n_checks++;
      if ({buf_wr, tlp_seq} !== {1'b0, 12'd5}) begin
         n_errors++;
         $display("FAIL accept_done: got wr=%b seq=%0d exp wr=0 seq=5", buf_wr, tlp_seq);
      end
   endtask

   task automatic test_full;
      int acc;
      do_reset;
      acc = 0;
      tlp_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (buf_wr) acc++;
         tick;
      end
      ack_nack = 2'b01;
      ack_seq  = 12'd7;
      #1;
      n_checks++;
      if ({acc[4:0], tlp_ready, buf_wr} !== {5'd16, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL full_stall: got acc=%0d ready=%b wr=%b exp acc=16 ready=0 wr=0",
                  acc, tlp_ready, buf_wr);
      end
      tick;
      ack_nack = 2'b00;
      #1;
      n_checks++;
      if ({tlp_ready, tlp_seq, dllp_err} !== {1'b1, 12'd16, 1'b0}) begin
         n_errors++;
         $display("FAIL full_after_ack: got ready=%b seq=%0d err=%b exp ready=1 seq=16 err=0",
                  tlp_ready, tlp_seq, dllp_err);
      end
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (buf_wr) acc++;
         tick;
      end
      #1;
      n_checks++;
      if ({acc[4:0], tlp_ready} !== {5'd8, 1'b0}) begin
         n_errors++;
         $display("FAIL full_out8: got acc=%0d ready=%b exp acc=8 ready=0", acc, tlp_ready);
      end
      tlp_valid = 1'b0;
   endtask

   task automatic test_nak_replay;
      do_reset;
      send_tlps(5);
      ack_nack = 2'b10;
      ack_seq  = 12'd1;
      tick;
      ack_nack = 2'b00;
      for (int i = 2; i < 5; i++) begin
         #1;
         n_checks++;
         if ({replay_active, buf_rd, replay_seq, buf_rd_idx} !== {1'b1, 1'b1, 12'(i), 4'(i)}) begin
            n_errors++;
            $display("FAIL nak_replay_%0d: got act=%b rd=%b seq=%0d idx=%0d exp act=1 rd=1 seq=%0d",
                     i, replay_active, buf_rd, replay_seq, buf_rd_idx, i);
         end
         tick;
      end
      #1;
      n_checks++;
      if ({replay_active, buf_rd, tlp_ready, tlp_seq} !== {1'b0, 1'b0, 1'b1, 12'd5}) begin
         n_errors++;
         $display("FAIL nak_replay_end: got act=%b rd=%b ready=%b nts=%0d exp 0 0 1 5",
                  replay_active, buf_rd, tlp_ready, tlp_seq);
      end
   endtask

   task automatic test_nak_stall;
      logic [5:0] pat;
      int k;
      pat = 6'b100101;
      k   = 2;
      do_reset;
      send_tlps(5);
      ack_nack = 2'b10;
      ack_seq  = 12'd1;
      tick;
      ack_nack = 2'b00;
      for (int j = 0; j < 6; j++) begin
         busy_n = pat[j];
         #1;
         n_checks++;
         if (pat[j]) begin
            if ({buf_rd, replay_seq} !== {1'b1, 12'(k)}) begin
               n_errors++;
               $display("FAIL stall_rd_%0d: got rd=%b seq=%0d exp rd=1 seq=%0d",
                        j, buf_rd, replay_seq, k);
            end
            k++;
         end else if ({replay_active, buf_rd} !== 2'b10) begin
            n_errors++;
            $display("FAIL stall_idle_%0d: got act=%b rd=%b exp act=1 rd=0",
                     j, replay_active, buf_rd);
         end
         tick;
      end
      busy_n = 1'b1;
      #1;
      n_checks++;
      if (replay_active !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_end: got act=%b exp 0", replay_active);
      end
   endtask

   task automatic test_window;
      do_reset;
      send_tlps(3);
      ack_nack = 2'b01;
      ack_seq  = 12'd9;
      tick;
      ack_seq  = 12'd4095;
      #1;
      n_checks++;
      if ({dllp_err, tlp_seq} !== {1'b1, 12'd3}) begin
         n_errors++;
         $display("FAIL window_err: got err=%b nts=%0d exp err=1 nts=3", dllp_err, tlp_seq);
      end
      tick;
      ack_nack = 2'b10;
      #1;
      n_checks++;
      if ({dllp_err, replay_active} !== 2'b00) begin
         n_errors++;
         $display("FAIL window_dup_ack: got err=%b act=%b exp 0 0", dllp_err, replay_active);
      end
      tick;
      ack_nack = 2'b00;
      #1;
      n_checks++;
      if ({dllp_err, buf_rd, replay_seq} !== {1'b0, 1'b1, 12'd0}) begin
         n_errors++;
         $display("FAIL window_dup_nak: got err=%b rd=%b seq=%0d exp err=0 rd=1 seq=0",
                  dllp_err, buf_rd, replay_seq);
      end
   endtask

   task automatic test_timeout;
      int early;
      int strobes;
      do_reset;
      send_tlps(3);
      early = 0;
      for (int cyc = 3; cyc < TIMEOUT; cyc++) begin
         #1;
         if (replay_active) early++;
         tick;
      end
      #1;
      n_checks++;
      if (early !== 0) begin
         n_errors++;
         $display("FAIL timeout_early: got %0d early active cycles exp 0", early);
      end
      n_checks++;
      if ({replay_active, buf_rd, replay_seq} !== {1'b1, 1'b1, 12'd0}) begin
         n_errors++;
         $display("FAIL timeout_start: got act=%b rd=%b seq=%0d exp act=1 rd=1 seq=0",
                  replay_active, buf_rd, replay_seq);
      end
      strobes = 0;
      for (int k = 0; k < 4 * TIMEOUT + 100; k++) begin
         if (retrain_req === 1'b1) break;
         if (buf_rd === 1'b1) strobes++;
         tick;
         #1;
      end
      n_checks++;
      if ({retrain_req, replay_active, strobes[7:0]} !== {1'b1, 1'b1, 8'd9}) begin
         n_errors++;
         $display("FAIL timeout_rollover: got req=%b act=%b strobes=%0d exp req=1 act=1 strobes=9",
                  retrain_req, replay_active, strobes);
      end
      tick;
      #1;
      n_checks++;
      if ({retrain_req, replay_active, buf_rd, tlp_ready} !== 4'b0100) begin
         n_errors++;
         $display("FAIL retrain_idle: got req=%b act=%b rd=%b ready=%b exp 0 1 0 0",
                  retrain_req, replay_active, buf_rd, tlp_ready);
      end
      for (int i = 0; i < 4; i++) tick;
      retrain_done = 1'b1;
      #1;
      tick;
      retrain_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if ({buf_rd, replay_seq} !== {1'b1, 12'(i)}) begin
            n_errors++;
            $display("FAIL retrain_replay_%0d: got rd=%b seq=%0d exp rd=1 seq=%0d",
                     i, buf_rd, replay_seq, i);
         end
         tick;
      end
      #1;
      n_checks++;
      if (replay_active !== 1'b0) begin
         n_errors++;
         $display("FAIL retrain_end: got act=%b exp 0", replay_active);
      end
   endtask

   task automatic test_ack_beats_timeout;
      do_reset;
      send_tlps(3);
      for (int cyc = 3; cyc < TIMEOUT - 1; cyc++) tick;
      ack_nack = 2'b01;
      ack_seq  = 12'd0;
      tick;
      ack_nack = 2'b00;
      #1;
      n_checks++;
      if ({replay_active, buf_rd, dllp_err} !== 3'b000) begin
         n_errors++;
         $display("FAIL ack_vs_timeout: got act=%b rd=%b err=%b exp 0 0 0",
                  replay_active, buf_rd, dllp_err);
      end
   endtask

   task automatic test_wrap;
      int miss;
      logic [11:0] exp_seq [4];
      exp_seq = '{12'd4094, 12'd4095, 12'd0, 12'd1};
      do_reset;
      miss = 0;
      tlp_valid = 1'b1;
      for (int k = 0; k < 4094; k++) begin
         ack_nack = (k == 0) ? 2'b00 : 2'b01;
         ack_seq  = 12'(k - 1);
         #1;
         if (!tlp_ready || dllp_err) miss++;
         tick;
      end
      n_checks++;
      if (miss !== 0) begin
         n_errors++;
         $display("FAIL wrap_preload: got %0d bad cycles exp 0", miss);
      end
      ack_nack = 2'b01;
      ack_seq  = 12'd4093;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if ({buf_wr, tlp_seq, buf_wr_idx} !== {1'b1, exp_seq[i], exp_seq[i][3:0]}) begin
            n_errors++;
            $display("FAIL wrap_accept_%0d: got wr=%b seq=%0d idx=%0d exp wr=1 seq=%0d",
                     i, buf_wr, tlp_seq, buf_wr_idx, exp_seq[i]);
         end
         tick;
         ack_nack = 2'b00;
      end
      tlp_valid = 1'b0;
      ack_nack  = 2'b10;
      ack_seq   = 12'd4095;
      tick;
      ack_nack = 2'b00;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++;
         if ({buf_rd, replay_seq, buf_rd_idx} !== {1'b1, 12'(i), 4'(i)}) begin
            n_errors++;
            $display("FAIL wrap_replay_%0d: got rd=%b seq=%0d idx=%0d exp rd=1 seq=%0d",
                     i, buf_rd, replay_seq, buf_rd_idx, i);
         end
         tick;
      end
      #1;
      n_checks++;
      if ({replay_active, tlp_seq} !== {1'b0, 12'd2}) begin
         n_errors++;
         $display("FAIL wrap_end: got act=%b nts=%0d exp act=0 nts=2", replay_active, tlp_seq);
      end
`ifdef REPLAY_STATS_EN
      n_checks++;
      if ({nak_cnt, replay_cnt, timeout_cnt} !== {16'd1, 16'd1, 16'd0}) begin
         n_errors++;
         $display("FAIL wrap_stats: got nak=%0d replay=%0d timeout=%0d exp 1 1 0",
                  nak_cnt, replay_cnt, timeout_cnt);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_accept;
      test_full;
      test_nak_replay;
      test_nak_stall;
      test_window;
      test_timeout;
      test_ack_beats_timeout;
      test_wrap;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
